// File: rtl/clk_div_multi.sv
// ============================================================================
// Module  : clk_div_multi
// Purpose : NUM_CH programmable 50%-duty clock dividers with tick strobes,
//           shadowed divisor writes and a global phase-align sync.
// Revision: 1.0
// ============================================================================
`default_nettype none

module clk_div_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 25000000,
  parameter int ADDR_W      = 2
) (
  input  logic              Clk_i,
  input  logic              Rst_i,
  input  logic [NUM_CH-1:0] En_i,
  input  logic              SyncReq_i,
  input  logic              WrEn_i,
  input  logic [ADDR_W-1:0] WrAddr_i,
  input  logic [CNT_W-1:0]  WrData_i,
  output logic [NUM_CH-1:0] ClkOut_o,
  output logic [NUM_CH-1:0] Tick_o
);

  localparam logic [CNT_W-1:0] c_DEF_DIV = CNT_W'(DEFAULT_DIV);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Addresses at or above NUM_CH match no channel, so those writes fall away.
    localparam logic [ADDR_W-1:0] c_IDX = ADDR_W'(i);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      pend_d = pend_q;
      clk_d  = clk_q;
      tick_d = 1'b0;

      if (WrEn_i && (WrAddr_i == c_IDX)) begin
        pend_d = WrData_i;
      end

      // ActDiv only reloads when the count restarts, so a half-period in
      // progress always finishes with the divisor it started with.
      if (!En_i[i] || SyncReq_i) begin
        cnt_d = '0;
        clk_d = 1'b0;
        act_d = pend_q;
      end else if (cnt_q == act_q) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        clk_d  = ~clk_q;
        act_d  = pend_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
      if (Rst_i) begin
        cnt_q  <= '0;
        act_q  <= c_DEF_DIV;
        pend_q <= c_DEF_DIV;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        pend_q <= pend_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end

    assign ClkOut_o[i] = clk_q;
    assign Tick_o[i]   = tick_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: a 4-channel and a 3-channel instance with DEFAULT_DIV=3,
// directed tables/sequences plus random stimulus against a rule-level model.
`default_nettype none

module tb_clk_div_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] en = '0;
  logic       sync = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] clk_a, tick_a;
  logic [2:0] clk_b, tick_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_div_multi #(.NUM_CH(4), .CNT_W(8), .DEFAULT_DIV(3), .ADDR_W(2)) dut_a (
    .Clk_i(clk), .Rst_i(rst), .En_i(en), .SyncReq_i(sync), .WrEn_i(wr_en),
    .WrAddr_i(wr_addr), .WrData_i(wr_data), .ClkOut_o(clk_a), .Tick_o(tick_a)
  );

  clk_div_multi #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(3), .ADDR_W(2)) dut_b (
    .Clk_i(clk), .Rst_i(rst), .En_i(en[2:0]), .SyncReq_i(sync), .WrEn_i(wr_en),
    .WrAddr_i(wr_addr), .WrData_i(wr_data), .ClkOut_o(clk_b), .Tick_o(tick_b)
  );

  // Rule-level reference: index 0 models the 4-channel instance, 1 the 3-channel one.
  int m_cnt [2][4];
  int m_act [2][4];
  int m_pend[2][4];
  bit m_clk [2][4];
  bit m_tick[2][4];

  always @(posedge clk or posedge rst) begin
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 4; c++) begin
        if (rst) begin
          m_cnt[m][c] <= 0; m_act[m][c] <= 3; m_pend[m][c] <= 3;
          m_clk[m][c] <= 1'b0; m_tick[m][c] <= 1'b0;
        end else if (c < ((m == 0) ? 4 : 3)) begin
          if (wr_en && (int'(wr_addr) == c)) m_pend[m][c] <= int'(wr_data);
          if (!en[c] || sync) begin
            m_cnt[m][c] <= 0; m_clk[m][c] <= 1'b0; m_tick[m][c] <= 1'b0;
            m_act[m][c] <= m_pend[m][c];
          end else if (m_cnt[m][c] == m_act[m][c]) begin
            m_cnt[m][c] <= 0; m_tick[m][c] <= 1'b1; m_clk[m][c] <= ~m_clk[m][c];
            m_act[m][c] <= m_pend[m][c];
          end else begin
            m_cnt[m][c] <= m_cnt[m][c] + 1; m_tick[m][c] <= 1'b0;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model();
    logic [3:0] ea, ta;
    logic [2:0] eb, tb;
    for (int c = 0; c < 4; c++) begin ea[c] = m_clk[0][c]; ta[c] = m_tick[0][c]; end
    for (int c = 0; c < 3; c++) begin eb[c] = m_clk[1][c]; tb[c] = m_tick[1][c]; end
    check("model_a", {24'd0, tick_a, clk_a}, {24'd0, ta, ea});
    check("model_b", {26'd0, tick_b, clk_b}, {26'd0, tb, eb});
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_tick(input int ch, output int n);
    n = 0;
    do begin step(); n++; end while (!tick_a[ch] && n < 300);
    if (!tick_a[ch]) n = -1;
  endtask

  task automatic wait_level(input int ch, input logic val, output int n);
    n = 0;
    do begin step(); n++; end while ((clk_a[ch] !== val) && n < 300);
    if (clk_a[ch] !== val) n = -1;
  endtask

  typedef struct {
    int ch;
    int div;
    int first_tick;
    int half;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n, k;
    logic [3:0] ec, et;
    int divs[4];

    tbl[0] = '{0, 0, 1, 1};
    tbl[1] = '{1, 1, 2, 2};
    tbl[2] = '{2, 4, 5, 5};
    tbl[3] = '{3, 9, 10, 10};

    repeat (3) step();
    rst = 1'b0;
    check("rst_clkout", {28'd0, clk_a}, 32'd0);
    check("rst_tick", {28'd0, tick_a}, 32'd0);

    // Reset mid-count: outputs drop at once and the pending write is discarded.
    en = 4'b0001;
    repeat (5) step();
    check("pre_rst_clk0", {31'd0, clk_a[0]}, 32'd1);
    wr(2'd0, 8'd7);
    #2 rst = 1'b1;
    #1;
    check("async_rst_clk", {25'd0, clk_b, clk_a}, 32'd0);
    check("async_rst_tick", {25'd0, tick_b, tick_a}, 32'd0);
    step();
    rst = 1'b0;
    wait_tick(0, n);  check("dflt_first_tick", n, 4);
    wait_level(0, 1'b0, n); check("dflt_high", n, 4);
    wait_level(0, 1'b1, n); check("dflt_low", n, 4);

    // Table: per-channel divisor, first tick latency and half-period.
    for (int r = 0; r < 4; r++) begin
      en = '0;
      wr(2'(tbl[r].ch), 8'(tbl[r].div));
      step(); step();
      en = 4'b0001 << tbl[r].ch;
      wait_tick(tbl[r].ch, n);
      check("tbl_first_tick", n, tbl[r].first_tick);
      check("tbl_clk_rise", {31'd0, clk_a[tbl[r].ch]}, 32'd1);
      wait_level(tbl[r].ch, 1'b0, n); check("tbl_high", n, tbl[r].half);
      wait_level(tbl[r].ch, 1'b1, n); check("tbl_low", n, tbl[r].half);
    end

    // Sync: mixed phases, then all channels follow k/(D+1) from the sync edge.
    for (int c = 0; c < 4; c++) divs[c] = tbl[c].div;
    en = 4'hF;
    repeat (7) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_clk", {28'd0, clk_a}, 32'd0);
    check("sync_tick", {28'd0, tick_a}, 32'd0);
    for (k = 1; k <= 40; k++) begin
      step();
      for (int c = 0; c < 4; c++) begin
        ec[c] = ((k / (divs[c] + 1)) % 2) == 1;
        et[c] = (k % (divs[c] + 1)) == 0;
      end
      check("sync_phase", {24'd0, tick_a, clk_a}, {24'd0, et, ec});
      chk_model();
    end

    // Disable ch1 while its output is high, then re-enable with D=9.
    n = 0;
    while (!clk_a[1] && n < 20) begin step(); n++; end
    check("dis_pre_high", {31'd0, clk_a[1]}, 32'd1);
    en[1] = 1'b0;
    step();
    check("dis_clk1", {31'd0, clk_a[1]}, 32'd0);
    check("dis_tick1", {31'd0, tick_a[1]}, 32'd0);
    wr(2'd1, 8'd9);
    step();
    en[1] = 1'b1;
    wait_tick(1, n); check("reen_first_tick", n, 10);

    // Mid-period update: write D=2 when Cnt=5 of a D=9 period.
    repeat (5) step();
    wr(2'd1, 8'd2);
    wait_tick(1, n); check("mid_finish_old", n, 4);
    wait_tick(1, n); check("mid_new_1", n, 3);
    wait_tick(1, n); check("mid_new_2", n, 3);

    // Write landing on ch2's terminal edge (D=4).
    wait_tick(2, n);
    repeat (4) step();
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'd7;
    step();
    wr_en = 1'b0;
    check("term_edge_tick", {31'd0, tick_a[2]}, 32'd1);
    wait_tick(2, n); check("term_old_pend", n, 5);
    wait_tick(2, n); check("term_new_div", n, 8);

    // Address 3 exists only on the 4-channel instance.
    wr(2'd3, 8'd0);
    repeat (20) begin step(); chk_model(); end

    // Random stimulus against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) en = 4'($urandom);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 2'($urandom);
      wr_data = 8'($urandom_range(0, 12));
      sync    = ($urandom_range(0, 59) == 0);
      rst     = ($urandom_range(0, 399) == 0);
      step();
      chk_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised multi-channel successor to the single fixed-rate 1 Hz divider.
- Generates NUM_CH independent divided clocks (50% duty square waves) plus single-cycle tick strobes from the 100 MHz board clock.
- Each channel's divisor is runtime-programmable through a simple write port. Channels can be enabled individually, and a global sync phase-aligns all channels.
- Sits beside the top level and feeds display scan, debounce and seconds-counter logic.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 26, counter and divisor width in bits.
- DEFAULT_DIV, 25000000, reset value of every channel's active and pending divisor. With a 100 MHz Clk this gives a 2 Hz ClkOut and a 4 Hz Tick.
- ADDR_W, 2, write address width; must satisfy 2**ADDR_W >= NUM_CH.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- En  in  NUM_CH  per-channel run enable.
- SyncReq  in  1  one-cycle pulse; restarts all channels in phase.
- WrEn  in  1  divisor write strobe.
- WrAddr  in  ADDR_W  channel index for the write.
- WrData  in  CNT_W  new divisor value D.
- ClkOut  out  NUM_CH  divided square wave per channel.
- Tick  out  NUM_CH  one-Clk-cycle strobe per channel at each terminal count.

Behaviour:
- One clock (Clk); reset Rst is asynchronous and active-high. All state is registered, with no combinational paths from inputs to outputs.
- Reset values: Cnt[i]=0, ClkOut=0, Tick=0, ActDiv[i]=PendDiv[i]=DEFAULT_DIV.
- Per channel, the registers are Cnt[i], ActDiv[i] (in use) and PendDiv[i] (shadow).
- Write: when WrEn=1 and WrAddr<NUM_CH, PendDiv[WrAddr]<=WrData on that edge. When WrAddr>=NUM_CH the write is ignored and no state changes. ActDiv never changes directly on a write.
- Per-channel priority, evaluated each edge, highest first:
  1. En[i]=0: Cnt<=0, ClkOut[i]<=0, Tick[i]<=0, ActDiv<=PendDiv. The channel is idle and tracks the pending value.
  2. SyncReq=1: Cnt<=0, ClkOut[i]<=0, Tick[i]<=0, ActDiv<=PendDiv.
  3. Cnt==ActDiv (terminal): Cnt<=0, Tick[i]<=1, ClkOut[i]<=~ClkOut[i], ActDiv<=PendDiv.
  4. Otherwise: Cnt<=Cnt+1, Tick[i]<=0, ClkOut[i] holds.
- Timing for a steady divisor D:
  - Tick period is D+1 cycles; the strobe is 1 cycle high.
  - ClkOut period is 2(D+1) cycles at exactly 50% duty.
  - The first Tick and the first ClkOut rise occur D+1 edges after En rises (or after SyncReq).
- D=0: Tick stays high continuously and ClkOut toggles every cycle (Clk/2).
- Divisor change is glitch-free. A new value takes effect only at the next terminal count, sync, or while disabled, so the current half-period always completes with the old divisor.
- Simultaneous write and terminal count (or sync) on the same channel: ActDiv takes the PendDiv value held before the edge, and the new write lands in PendDiv for the following period.
- The counter compare is equality only. Because ActDiv only changes at Cnt=0, Cnt can never pass ActDiv, and no wrap-around beyond 2**CNT_W-1 is possible.
- SyncReq affects enabled channels only; disabled channels are already held at zero.
- Asynchronous Rst mid-period forces all outputs low immediately and discards pending writes.

Test Plan:
- Reset and defaults: set DEFAULT_DIV=3 in the bench, assert Rst mid-count. Expect ClkOut=0 and Tick=0 immediately. Then with En=4'b0001, expect ch0 Tick every 4 cycles and ClkOut period 8 cycles with 4 high / 4 low.
- Per-channel divisors: write ch0=0, ch1=1, ch2=4, ch3=9, then set En=4'hF. Expect ClkOut periods of 2, 4, 10 and 20 cycles, ch0 Tick constantly high, and all first Ticks on cycles 1, 2, 5 and 10 after enable.
- Mid-period update: ch1 running D=9. Write D=2 at Cnt=5. Expect Cnt to continue to 9 and toggle, after which half-periods are 3 cycles. No ClkOut pulse shorter than 3 cycles.
- Write on terminal edge: write ch2=7 on the same edge where Cnt==ActDiv=4. Expect the next half-period to use D=4 (old PendDiv) and the one after to use 7.
- SyncReq: all channels running with mixed phases; pulse SyncReq. Next cycle, all ClkOut=0 and Cnt=0, and subsequent rising edges align to the common multiple.
- Enable, disable and bad address: write WrAddr=3 with NUM_CH=3 and confirm no state change. Drop En[1] mid-count and confirm ClkOut[1]=0 next edge. Re-enable and confirm the first Tick comes D+1 cycles later.
